// File: rtl/seq_stream_gen_if.sv
// Load/stream bundle between a host or sequencer and seq_stream_gen.
// The master drives load/pattern/len. The slave (the generator) drives the stream outputs.
interface seq_stream_gen_if #(
   parameter int W  = 8,
   parameter int LW = $clog2(W + 1)
);
   logic          load;
   logic [W-1:0]  pattern;
   logic [LW-1:0] len;
   logic          ready;
   logic          det_rst;
   logic          x;
   logic          valid;
   logic          done;

   // Handshake: a load is taken on a rising edge only when ready=1 and len!=0.
   // Once taken, ready stays low until the stream's done pulse has been issued.
   // While ready=0, load is neither sampled nor remembered.
   // Each cycle with valid=1 carries one pattern bit on x. x is 0 whenever valid=0.
   modport master (output load, pattern, len,
                   input  ready, det_rst, x, valid, done);
   modport slave  (input  load, pattern, len,
                   output ready, det_rst, x, valid, done);
endinterface

// File: rtl/seq_stream_gen.sv
// Serialises a captured pattern MSB-first after a one-cycle detector reset,
// then pulses done. Every output comes from a register.
module seq_stream_gen #(
   parameter int W  = 8,
   parameter int LW = $clog2(W + 1)
) (
   input  logic               clk,
   input  logic               rst,
   seq_stream_gen_if.slave    bus,
   output logic [1:0]         o_state
);
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RST   = 2'd1,
      S_SHIFT = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t        r_state, w_state_nx;
   logic [W-1:0]  r_sr, w_sr_nx;
   logic [LW-1:0] r_cnt, w_cnt_nx;
   logic          r_ready, r_det_rst, r_x, r_valid, r_done;
   logic          w_x_nx;
   logic [LW-1:0] w_eff;
   logic [LW-1:0] w_shamt;

   // Lengths above W are clamped to W. The pattern is then left-aligned so that
   // bit len-1 sits in the MSB and the stream always shifts out of r_sr[W-1].
   assign w_eff   = (bus.len > LW'(W)) ? LW'(W) : bus.len;
   assign w_shamt = LW'(W) - w_eff;

   always_comb begin
      w_state_nx = r_state;
      w_sr_nx    = r_sr;
      w_cnt_nx   = r_cnt;
      w_x_nx     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.load && (bus.len != '0)) begin
               w_state_nx = S_RST;
               w_sr_nx    = bus.pattern << w_shamt;
               w_cnt_nx   = w_eff;
            end
         end
         S_RST: begin
            w_state_nx = S_SHIFT;
            w_x_nx     = r_sr[W-1];
            w_sr_nx    = r_sr << 1;
         end
         S_SHIFT: begin
            // r_cnt counts the bits still to be shown, including the one on x now.
            if (r_cnt == LW'(1)) begin
               w_state_nx = S_DONE;
            end else begin
               w_x_nx   = r_sr[W-1];
               w_sr_nx  = r_sr << 1;
               w_cnt_nx = r_cnt - LW'(1);
            end
         end
         S_DONE: begin
            w_state_nx = S_IDLE;
         end
         default: begin
            w_state_nx = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_sr      <= '0;
         r_cnt     <= '0;
         r_ready   <= 1'b1;
         r_det_rst <= 1'b1;
         r_x       <= 1'b0;
         r_valid   <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_state_nx;
         r_sr      <= w_sr_nx;
         r_cnt     <= w_cnt_nx;
         r_ready   <= (w_state_nx == S_IDLE);
         r_det_rst <= (w_state_nx == S_RST);
         r_x       <= w_x_nx;
         r_valid   <= (w_state_nx == S_SHIFT);
         r_done    <= (w_state_nx == S_DONE);
      end
   end

   assign bus.ready   = r_ready;
   assign bus.det_rst = r_det_rst;
   assign bus.x       = r_x;
   assign bus.valid   = r_valid;
   assign bus.done    = r_done;
   assign o_state     = r_state;
endmodule

// File: tb/tb_seq_stream_gen.sv
// Self-checking bench for seq_stream_gen. Expected bit streams are derived from
// the pattern/len rules: min(len,W) bits, pattern[len-1] first.
module tb_seq_stream_gen;
   localparam int W  = 8;
   localparam int LW = $clog2(W + 1);

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [1:0] dbg_state;
   int         n_checks = 0;
   int         n_fail   = 0;
   logic       exp_q[$];

   seq_stream_gen_if #(.W(W)) bus ();

   seq_stream_gen #(.W(W)) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus),
      .o_state (dbg_state)
   );

   always #5 clk = ~clk;

   // Reference model: the serial stream as a list of bits.
   function automatic void build_exp(input logic [W-1:0] pat, input int len);
      int eff;
      exp_q.delete();
      eff = (len > W) ? W : len;
      for (int i = eff - 1; i >= 0; i--) exp_q.push_back(pat[i]);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      bus.load = 1'b0; bus.pattern = '0; bus.len = '0;
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if ({bus.ready, bus.det_rst, bus.x, bus.valid, bus.done} !== 5'b11000) begin
         n_fail++;
         $display("FAIL reset_async: rdy/drst/x/v/done=%b want 11000",
                  {bus.ready, bus.det_rst, bus.x, bus.valid, bus.done});
      end
      @(posedge clk); @(posedge clk);
      @(negedge clk) rst = 1'b0;
      #1;
      n_checks++;
      if (bus.det_rst !== 1'b1) begin
         n_fail++; $display("FAIL reset_hold_drst: got %b want 1", bus.det_rst);
      end
      tick();
      n_checks++;
      if ({bus.ready, bus.det_rst, bus.valid, bus.done} !== 4'b1000) begin
         n_fail++;
         $display("FAIL reset_release: rdy/drst/v/done=%b want 1000",
                  {bus.ready, bus.det_rst, bus.valid, bus.done});
      end
   endtask

   task automatic test_streams();
      logic [W-1:0] pats [3];
      int           lens [3];
      logic [W-1:0] pat;
      int           len;
      pats = '{8'b00000101, 8'b00010100, 8'b01000001};
      lens = '{3, 7, 7};
      for (int t = 0; t < 9; t++) begin
         if (t < 3) begin
            pat = pats[t]; len = lens[t];
         end else begin
            pat = W'($urandom); len = $urandom_range(1, W);
         end
         build_exp(pat, len);
         bus.pattern = pat; bus.len = LW'(len); bus.load = 1'b1;
         tick();
         bus.load = 1'b0;
         n_checks++;
         if ({bus.det_rst, bus.ready, bus.valid, bus.x} !== 4'b1000) begin
            n_fail++;
            $display("FAIL stream%0d_rst: drst/rdy/v/x=%b want 1000", t,
                     {bus.det_rst, bus.ready, bus.valid, bus.x});
         end
         for (int i = 0; i < exp_q.size(); i++) begin
            bus.pattern = W'($urandom); bus.len = LW'($urandom);
            tick();
            n_checks++;
            if ({bus.valid, bus.x, bus.det_rst, bus.done} !== {1'b1, exp_q[i], 2'b00}) begin
               n_fail++;
               $display("FAIL stream%0d_bit%0d: v/x/drst/done=%b want %b", t, i,
                        {bus.valid, bus.x, bus.det_rst, bus.done}, {1'b1, exp_q[i], 2'b00});
            end
         end
         tick();
         n_checks++;
         if ({bus.done, bus.valid, bus.x, bus.ready} !== 4'b1000) begin
            n_fail++;
            $display("FAIL stream%0d_done: done/v/x/rdy=%b want 1000", t,
                     {bus.done, bus.valid, bus.x, bus.ready});
         end
         tick();
         n_checks++;
         if ({bus.ready, bus.done, bus.det_rst, bus.valid} !== 4'b1000) begin
            n_fail++;
            $display("FAIL stream%0d_idle: rdy/done/drst/v=%b want 1000", t,
                     {bus.ready, bus.done, bus.det_rst, bus.valid});
         end
      end
   endtask

   task automatic test_load_during_shift();
      logic [W-1:0] pat;
      pat = 8'b10110010;
      build_exp(pat, 8);
      bus.pattern = pat; bus.len = LW'(8); bus.load = 1'b1;
      tick();
      bus.load = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (i >= 2 && i < 6) begin
            bus.load = 1'b1; bus.pattern = ~pat; bus.len = LW'(5);
         end else begin
            bus.load = 1'b0;
         end
         tick();
         n_checks++;
         if ({bus.valid, bus.x} !== {1'b1, exp_q[i]}) begin
            n_fail++;
            $display("FAIL busy_load_bit%0d: v/x=%b want %b", i,
                     {bus.valid, bus.x}, {1'b1, exp_q[i]});
         end
      end
      bus.load = 1'b0;
      tick();
      n_checks++;
      if (bus.done !== 1'b1) begin
         n_fail++; $display("FAIL busy_load_done: got %b want 1", bus.done);
      end
      tick(); tick();
      n_checks++;
      if ({bus.ready, bus.det_rst, bus.valid} !== 3'b100) begin
         n_fail++;
         $display("FAIL busy_load_dropped: rdy/drst/v=%b want 100",
                  {bus.ready, bus.det_rst, bus.valid});
      end
   endtask

   task automatic test_len_zero();
      bus.len = '0; bus.load = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.pattern = W'($urandom);
         tick();
         n_checks++;
         if ({bus.ready, bus.det_rst, bus.valid, bus.x, bus.done} !== 5'b10000) begin
            n_fail++;
            $display("FAIL len_zero_c%0d: rdy/drst/v/x/done=%b want 10000", i,
                     {bus.ready, bus.det_rst, bus.valid, bus.x, bus.done});
         end
      end
      bus.load = 1'b0;
   endtask

   task automatic test_len_over();
      logic [W-1:0] pat;
      int           nbits;
      pat = W'($urandom) | 8'h81;
      build_exp(pat, 12);
      bus.pattern = pat; bus.len = LW'(12); bus.load = 1'b1;
      tick();
      bus.load = 1'b0;
      nbits = 0;
      for (int i = 0; i < 12 && !bus.done; i++) begin
         tick();
         if (bus.valid) begin
            n_checks++;
            if (nbits >= exp_q.size() || bus.x !== exp_q[nbits]) begin
               n_fail++;
               $display("FAIL len_over_bit%0d: x=%b pat=%b", nbits, bus.x, pat);
            end
            nbits++;
         end
      end
      n_checks++;
      if (nbits != 8 || bus.done !== 1'b1) begin
         n_fail++;
         $display("FAIL len_over_count: bits=%0d done=%b want 8 bits then done", nbits, bus.done);
      end
      tick();
   endtask

   task automatic test_mid_reset();
      logic [W-1:0] pat;
      pat = 8'b00101101;
      bus.pattern = pat; bus.len = LW'(6); bus.load = 1'b1;
      tick();
      bus.load = 1'b0;
      tick(); tick();
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if ({bus.x, bus.valid, bus.det_rst, bus.ready, bus.done} !== 5'b00110) begin
         n_fail++;
         $display("FAIL mid_reset: x/v/drst/rdy/done=%b want 00110",
                  {bus.x, bus.valid, bus.det_rst, bus.ready, bus.done});
      end
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      tick();
      n_checks++;
      if ({bus.det_rst, bus.ready} !== 2'b01) begin
         n_fail++; $display("FAIL mid_reset_release: drst/rdy=%b want 01", {bus.det_rst, bus.ready});
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         n_checks++;
         if ({bus.done, bus.valid} !== 2'b00) begin
            n_fail++; $display("FAIL mid_reset_quiet_c%0d: done/v=%b want 00", i, {bus.done, bus.valid});
         end
      end
      pat = 8'b00110110;
      build_exp(pat, 6);
      bus.pattern = pat; bus.len = LW'(6); bus.load = 1'b1;
      tick();
      bus.load = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         n_checks++;
         if ({bus.valid, bus.x} !== {1'b1, exp_q[i]}) begin
            n_fail++;
            $display("FAIL fresh_bit%0d: v/x=%b want %b", i, {bus.valid, bus.x}, {1'b1, exp_q[i]});
         end
      end
      tick();
      n_checks++;
      if (bus.done !== 1'b1) begin
         n_fail++; $display("FAIL fresh_done: got %b want 1", bus.done);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] pat;
      pat = 8'b11100011;
      build_exp(pat, 8);
      bus.pattern = pat; bus.len = LW'(8); bus.load = 1'b1;
      tick();
      for (int s = 0; s < 2; s++) begin
         n_checks++;
         if ({bus.det_rst, bus.ready} !== 2'b10) begin
            n_fail++; $display("FAIL b2b%0d_rst: drst/rdy=%b want 10", s, {bus.det_rst, bus.ready});
         end
         for (int i = 0; i < 8; i++) begin
            tick();
            n_checks++;
            if ({bus.valid, bus.x} !== {1'b1, exp_q[i]}) begin
               n_fail++;
               $display("FAIL b2b%0d_bit%0d: v/x=%b want %b", s, i, {bus.valid, bus.x}, {1'b1, exp_q[i]});
            end
         end
         tick();
         n_checks++;
         if (bus.done !== 1'b1) begin
            n_fail++; $display("FAIL b2b%0d_done: got %b want 1", s, bus.done);
         end
         tick();
         n_checks++;
         if ({bus.ready, bus.det_rst} !== 2'b10) begin
            n_fail++; $display("FAIL b2b%0d_ready: rdy/drst=%b want 10", s, {bus.ready, bus.det_rst});
         end
         if (s == 1) bus.load = 1'b0;
         tick();
      end
      n_checks++;
      if ({bus.ready, bus.det_rst} !== 2'b10) begin
         n_fail++; $display("FAIL b2b_stop: rdy/drst=%b want 10", {bus.ready, bus.det_rst});
      end
   endtask

   initial begin
      test_reset();
      test_streams();
      test_load_during_shift();
      test_len_zero();
      test_len_over();
      test_mid_reset();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
